// File: rtl/serial_paralelo.sv
// rtl/serial_paralelo.sv - comma-aligned serial-to-parallel byte deserializer
module serial_paralelo #(
   parameter logic [7:0] COMMA       = 8'hBC,
   parameter int         COMMA_COUNT = 4
) (
   input  logic       clk16f,
   input  logic       reset,
   input  logic       serial_in,
   output logic [8:0] paralelo_out,
   output logic       word_strobe,
   output logic       active
);

   // Counter only has to reach COMMA_COUNT; it saturates there.
   localparam int             CW       = $clog2(COMMA_COUNT + 1);
   localparam logic [CW-1:0]  C_TARGET = CW'(COMMA_COUNT);
   localparam logic [CW-1:0]  C_ONE    = CW'(1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_sr;
   logic [2:0]      r_bit_cnt;
   logic [2:0]      w_bit_cnt_nxt;
   logic [CW-1:0]   r_comma_cnt;
   logic [CW-1:0]   w_comma_cnt_nxt;
   logic [8:0]      r_out;
   logic [8:0]      w_out_nxt;
   logic            r_strobe;
   logic            w_strobe_nxt;

   logic [7:0]      w_word;
   logic            w_boundary;
   logic            w_is_comma;

   // The byte completing at this edge includes the bit being sampled now.
   assign w_word     = {r_sr[6:0], serial_in};
   assign w_boundary = (r_bit_cnt == 3'd7);
   assign w_is_comma = (w_word == COMMA);

   // Next-state, alignment bookkeeping and output word selection.
   always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
      w_comma_cnt_nxt = r_comma_cnt;
      w_out_nxt       = r_out;
      w_strobe_nxt    = 1'b0;
      case (r_state)
         SEARCH: begin
            // Any comma, at any bit offset, fixes the byte phase here.
            if (w_is_comma) begin
               w_bit_cnt_nxt   = 3'd0;
               w_comma_cnt_nxt = C_ONE;
               w_state_nxt     = (COMMA_COUNT == 1) ? ACTIVE : ALIGN;
            end
         end
         ALIGN: begin
            if (w_boundary) begin
               if (w_is_comma) begin
                  if (r_comma_cnt >= (C_TARGET - C_ONE)) begin
                     w_comma_cnt_nxt = C_TARGET;
                     w_state_nxt     = ACTIVE;
                  end else begin
                     w_comma_cnt_nxt = r_comma_cnt + C_ONE;
                  end
               end else begin
                  w_comma_cnt_nxt = '0;
                  w_state_nxt     = SEARCH;
               end
            end
         end
         ACTIVE: begin
            // Phase is locked; commas only mark idle words, never realign.
            if (w_boundary) begin
               w_out_nxt    = w_is_comma ? {1'b0, COMMA} : {1'b1, w_word};
               w_strobe_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt     = SEARCH;
            w_comma_cnt_nxt = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk16f) begin
      if (reset) begin
         r_state     <= SEARCH;
         r_sr        <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_comma_cnt <= '0;
         r_out       <= 9'h000;
         r_strobe    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sr        <= w_word;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_comma_cnt <= w_comma_cnt_nxt;
         r_out       <= w_out_nxt;
         r_strobe    <= w_strobe_nxt;
      end
   end

   assign paralelo_out = r_out;
   assign word_strobe  = r_strobe;
   assign active       = (r_state == ACTIVE);

endmodule
